// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with a registered result/zero behind a valid/ready handshake.
// Define ALU_EXEC_MUL_EN to build the iterative unsigned multiply for alu_op 011.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal_op
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;
`ifdef ALU_EXEC_MUL_EN
    localparam logic [2:0] OP_MUL = 3'b011;
`endif

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;

    logic             accept;
    logic             res_free;
    logic             op_is_mul;
    logic             op_illegal;
    logic [WIDTH-1:0] op_result;

`ifdef ALU_EXEC_MUL_EN
    // state | meaning
    // IDLE  | accepting ops, single-cycle results written on accept
    // MUL   | shift-add iteration, one multiplier bit per cycle
    // DONE  | product ready, waiting for the result register to be free
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int              CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    assign op_is_mul = (alu_op == OP_MUL);
    assign in_ready  = !flush && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
`else
    // Without the multiplier the unit is never busy, so only the result register gates issue.
    assign op_is_mul = 1'b0;
    assign in_ready  = !flush && (!out_valid_q || out_ready);
`endif

    assign res_free = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        op_result  = '0;
        op_illegal = 1'b0;
        case (alu_op)
            OP_ADD: op_result = a + b;
            OP_SUB: op_result = a - b;
            OP_SLT: op_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_AND: op_result = a & b;
            OP_OR:  op_result = a | b;
`ifdef ALU_EXEC_MUL_EN
            OP_MUL: op_result = '0;
`endif
            default: op_illegal = 1'b1;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        illegal_d   = 1'b0;
`ifdef ALU_EXEC_MUL_EN
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
`endif
        if (flush) begin
            out_valid_d = 1'b0;
`ifdef ALU_EXEC_MUL_EN
            state_d = ST_IDLE;
`endif
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
`ifdef ALU_EXEC_MUL_EN
            case (state_q)
                ST_IDLE: begin
                    if (accept && op_is_mul) begin
                        state_d  = ST_MUL;
                        cnt_d    = CNT_LOAD;
                        mcand_d  = a;
                        mplier_d = b;
                        acc_d    = '0;
                    end
                end
                ST_MUL: begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q - CNT_LAST;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (res_free) begin
                        result_d    = acc_q;
                        zero_d      = (acc_q == '0);
                        out_valid_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
`endif
            if (accept && !op_is_mul) begin
                result_d    = op_result;
                zero_d      = (op_result == '0);
                out_valid_d = 1'b1;
                illegal_d   = op_illegal;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
`ifdef ALU_EXEC_MUL_EN
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
`endif
        end
    end

    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign zero       = zero_q;
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: transaction-level model plus directed vectors.
// Multiply scenarios are built when ALU_EXEC_MUL_EN is defined.
module tb_alu_exec_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   alu_op = 3'b000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         flush = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         zero;
    logic         illegal_op;

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_op     (alu_op),
        .a          (a),
        .b          (b),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: what the result register must hold, and how long a multiply keeps the unit busy.
    bit           exp_valid   = 1'b0;
    logic [W-1:0] exp_result  = '0;
    bit           exp_zero    = 1'b0;
    bit           exp_illegal = 1'b0;
    int           mul_left    = 0;
    logic [W-1:0] mul_product = '0;

    function automatic bit is_mul(input logic [2:0] op);
`ifdef ALU_EXEC_MUL_EN
        return op == 3'b011;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit is_legal(input logic [2:0] op);
        return op == 3'b010 || op == 3'b110 || op == 3'b111 || op == 3'b000 || op == 3'b001 || is_mul(op);
    endfunction

    function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (op)
            3'b010: return x + y;
            3'b110: return x - y;
            3'b111: return (sx < sy) ? 1 : 0;
            3'b000: return x & y;
            3'b001: return x | y;
            3'b011: return is_mul(op) ? W'(64'(x) * 64'(y)) : '0;
            default: return '0;
        endcase
    endfunction

    function automatic bit model_ready();
        return !flush && mul_left == 0 && (!exp_valid || out_ready);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_valid   = 1'b0;
            exp_result  = '0;
            exp_zero    = 1'b0;
            exp_illegal = 1'b0;
            mul_left    = 0;
        end else if (flush) begin
            exp_valid   = 1'b0;
            exp_illegal = 1'b0;
            mul_left    = 0;
        end else begin
            bit rdy;
            rdy = model_ready();
            exp_illegal = 1'b0;
            if (mul_left > 0) begin
                mul_left--;
                if (mul_left == 0) begin
                    exp_valid  = 1'b1;
                    exp_result = mul_product;
                    exp_zero   = (mul_product == '0);
                end
            end else if (in_valid && rdy) begin
                if (is_mul(alu_op)) begin
                    mul_left    = W + 1;
                    mul_product = ref_op(alu_op, a, b);
                    exp_valid   = 1'b0;
                end else begin
                    exp_valid   = 1'b1;
                    exp_result  = ref_op(alu_op, a, b);
                    exp_zero    = (exp_result == '0);
                    exp_illegal = !is_legal(alu_op);
                end
            end else if (exp_valid && out_ready) begin
                exp_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            check("mon_in_ready", in_ready, model_ready());
            check("mon_out_valid", out_valid, exp_valid);
            check("mon_illegal", illegal_op, exp_illegal);
            if (exp_valid) begin
                check("mon_result", result, exp_result);
                check("mon_zero", zero, exp_zero);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        in_valid = 1'b1;
        alu_op   = op;
        a        = x;
        b        = y;
        step(1);
        in_valid = 1'b0;
    endtask

    logic [2:0]   v_op  [11] = '{3'b010, 3'b010, 3'b110, 3'b110, 3'b111, 3'b111,
                                 3'b111, 3'b111, 3'b000, 3'b001, 3'b111};
    logic [W-1:0] v_a   [11] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0, 32'd10, 32'd5, 32'd7,
                                 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_0000, 32'hF000_0000, 32'hFFFF_FFFD};
    logic [W-1:0] v_b   [11] = '{32'h1, 32'h1, 32'h1, 32'd3, 32'd7, 32'd5,
                                 32'h7FFF_FFFF, 32'h8000_0000, 32'h1234_5678, 32'h0000_000F, 32'hFFFF_FFFE};
    logic [W-1:0] v_exp [11] = '{32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd7, 32'd1, 32'd0,
                                 32'd1, 32'd0, 32'h1234_0000, 32'hF000_000F, 32'd1};

    initial begin
        step(2);
        check("reset_out_valid", out_valid, 0);
        check("reset_result", result, 0);
        check("reset_zero", zero, 0);
        check("reset_illegal", illegal_op, 0);
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", in_ready, 1);
        mon_en = 1'b1;

        out_ready = 1'b1;
        issue(3'b010, 32'd5, 32'd7);
        check("add_valid", out_valid, 1);
        check("add_result", result, 32'd12);
        check("add_zero", zero, 0);

        issue(3'b110, 32'd9, 32'd9);
        check("sub_result", result, 32'd0);
        check("sub_zero", zero, 1);
        issue(3'b111, 32'hFFFF_FFFF, 32'd1);
        check("slt_neg_result", result, 32'd1);
        step(1);

        // Back-pressure: result held while an or-op waits, then drain+accept in one edge.
        out_ready = 1'b0;
        issue(3'b000, 32'h0000_F0F0, 32'h0000_0FF0);
        in_valid = 1'b1;
        alu_op   = 3'b001;
        a        = 32'h0000_1200;
        b        = 32'h0000_0034;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", in_ready, 0);
            check("bp_result_hold", result, 32'h0000_00F0);
            check("bp_valid_hold", out_valid, 1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        step(1);
        in_valid = 1'b0;
        check("b2b_valid", out_valid, 1);
        check("b2b_result", result, 32'h0000_1234);
        step(1);
        check("drain_valid", out_valid, 0);

        issue(3'b101, 32'd3, 32'd4);
        check("illegal_pulse", illegal_op, 1);
        check("illegal_result", result, 0);
        check("illegal_zero", zero, 1);
        check("illegal_valid", out_valid, 1);
        step(1);
        check("illegal_one_cycle", illegal_op, 0);
        issue(3'b100, 32'd1, 32'd1);
        check("illegal100_pulse", illegal_op, 1);
        step(1);

        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1;
            alu_op   = v_op[i];
            a        = v_a[i];
            b        = v_b[i];
            step(1);
            check($sformatf("vec%0d_result", i), result, v_exp[i]);
            check($sformatf("vec%0d_zero", i), zero, v_exp[i] == '0);
        end
        in_valid = 1'b0;
        step(1);

        // Flush while a result is pending and a new op is offered.
        out_ready = 1'b0;
        issue(3'b010, 32'd1, 32'd1);
        check("pre_flush_valid", out_valid, 1);
        flush    = 1'b1;
        in_valid = 1'b1;
        alu_op   = 3'b010;
        a        = 32'd3;
        b        = 32'd4;
        #1;
        check("flush_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", out_valid, 0);
        out_ready = 1'b1;
        step(2);
        check("flush_not_accepted", out_valid, 0);

`ifdef ALU_EXEC_MUL_EN
        begin
            int lat;
            lat = 0;
            issue(3'b011, 32'd1234, 32'd567);
            for (int n = 1; n <= W + 5; n++) begin
                if (out_valid) begin
                    lat = n - 1;
                    break;
                end
                check("mul_busy_in_ready", in_ready, 0);
                step(1);
            end
            check("mul_latency", lat, W + 1);
            check("mul_result", result, 32'd699678);
            check("mul_zero", zero, 0);
            step(1);
        end
        issue(3'b011, 32'd3, 32'd5);
        step(4);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        check("mul_flush_ready", in_ready, 1);
        step(W + 3);
        check("mul_flush_no_result", out_valid, 0);

        issue(3'b011, 32'd77, 32'd99);
        step(10);
        #1;
        rst_n = 1'b0;
        #1;
        check("mul_rst_valid", out_valid, 0);
        check("mul_rst_ready", in_ready, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        issue(3'b010, 32'd20, 32'd22);
        check("post_rst_add", result, 32'd42);
        step(1);
`else
        issue(3'b011, 32'd1234, 32'd567);
        check("mul_off_illegal", illegal_op, 1);
        check("mul_off_result", result, 0);
        check("mul_off_zero", zero, 1);
        step(1);
`endif

        out_ready = 1'b0;
        issue(3'b001, 32'h10, 32'h01);
        check("pre_rst_result", result, 32'h11);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_zero", zero, 0);
        check("rst_illegal", illegal_op, 0);
        @(posedge clk);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("rst_release_ready", in_ready, 1);
        step(2);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU of the pipelined MIPS datapath; consumes the 3-bit alu_op produced by the ALU controller plus two operands.
- Delivers a registered result and zero flag to the EX/MEM boundary through a valid/ready handshake.
- Single-cycle ops complete in one cycle; the optional multiply is iterative and holds off new issue while busy.
- Supports pipeline flush for branch mispredicts.

Parameters:
- WIDTH, 32, operand and result width in bits (at least 4)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and op presented this cycle
- in_ready  output  1  unit accepts an op this cycle
- alu_op  input  3  010 add, 110 sub, 111 slt, 000 and, 001 or, 011 mul (optional only)
- a  input  WIDTH  operand A (rs)
- b  input  WIDTH  operand B (rt or immediate)
- flush  input  1  discard the in-flight op and any pending result
- out_valid  output  1  result register holds a valid result
- out_ready  input  1  downstream (EX/MEM) consumes the result
- result  output  WIDTH  operation result
- zero  output  1  result == 0, used for beq/bne
- illegal_op  output  1  pulses one cycle when an undefined alu_op is accepted

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, result=0, zero=0, illegal_op=0, FSM=IDLE.
  - in_ready is combinational and reads 1 as soon as reset is released.
- Accept: transfer occurs when in_valid && in_ready at a rising edge.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This gives full throughput with back-pressure and needs no skid buffer.
- Single-cycle ops:
  - result registered on the accept edge; out_valid=1 on the next cycle (latency 1).
  - add/sub wrap modulo 2^WIDTH with no overflow flag.
  - slt is a signed compare; result is 1 or 0, zero-extended.
  - and/or are bitwise.
- zero is registered together with result; it is only meaningful while out_valid=1.
- Output hold: while out_valid && !out_ready, result and zero stay stable and no accept occurs.
- Drain: out_ready && out_valid with no new accept clears out_valid next cycle.
- Simultaneous drain and accept: out_valid stays 1 and result is replaced (back-to-back).
- Undefined alu_op (100, 101, 011 when the multiply is compiled out):
  - result=0, zero=1, out_valid=1.
  - illegal_op=1 for exactly the cycle after the accept.
- flush:
  - Synchronous; takes priority over everything.
  - Next cycle: out_valid=0, FSM=IDLE, any multiply aborted, illegal_op=0.
  - An op presented in the same cycle as flush is not accepted (in_ready is forced 0 while flush=1).
- FSM states: IDLE, MUL, DONE.
  - In the base build only IDLE is reachable.
  - The transitions are defined under Optional Feature.

Optional Feature:
Macro ALU_EXEC_MUL_EN.
- Defined:
  - alu_op 011 = unsigned multiply, low WIDTH bits of the product.
  - Executed by a shift-add iterator with a count-down counter of $clog2(WIDTH) + 1 bits.
  - Accept moves IDLE->MUL with the counter loaded to WIDTH.
  - Each MUL cycle processes one multiplier bit; when the counter reaches 0 the FSM moves to DONE.
  - DONE writes result and zero, sets out_valid, then returns to IDLE once the result register can take it (!out_valid || out_ready).
  - Latency from accept to out_valid is WIDTH+1 cycles; in_ready=0 throughout MUL and DONE.
  - flush in MUL or DONE returns the FSM to IDLE with no result.
- Undefined: 011 is treated as an illegal op, the MUL and DONE states plus the counter are not synthesised, and in_ready depends only on out_valid/out_ready.

Test Plan:
- Reset and basic add: release rst_n, a=5, b=7, op=010, out_ready=1 -> in_ready=1; next cycle out_valid=1, result=12, zero=0.
- sub zero and slt signed: a=9, b=9, op=110 -> result=0, zero=1. Then a=0xFFFFFFFF, b=1, op=111 -> result=1.
- Back-pressure: issue and(0xF0F0, 0x0FF0) with out_ready=0 -> result=0x00F0 holds, in_ready=0 for 3 cycles. Raise out_ready with an or-op queued -> back-to-back accept, next result correct.
- Illegal op: op=101 -> result=0, zero=1, illegal_op high for exactly 1 cycle.
- Flush: flush asserted while out_valid=1 and in_valid=1 -> next cycle out_valid=0 and the op is not accepted.
  - With ALU_EXEC_MUL_EN, flush 5 cycles into a multiply -> IDLE, no result.
- Multiply (ALU_EXEC_MUL_EN): a=1234, b=567, op=011 -> in_ready=0 for the busy period; out_valid exactly WIDTH+1 cycles after accept; result=699678.
- Async reset mid-multiply: deassert clock edges, pulse rst_n low -> outputs clear immediately, FSM=IDLE.
